// File: rtl/npc_branch_ext_unit_pkg.sv
// npc_branch_ext_unit_pkg: shared opcode/REGIMM constants and width defaults for the next-PC helper.
package npc_branch_ext_unit_pkg;
  localparam int AW_DEF = 30;
  localparam int IW_DEF = 16;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;
endpackage

// File: rtl/npc_branch_ext_unit_offset_ext.sv
// npc_offset_ext: sign- or zero-extends an IW-bit immediate to OW bits.
module npc_offset_ext #(
  parameter int IW = 16,
  parameter int OW = 30
) (
  input  logic          ext_op,
  input  logic [IW-1:0] imm,
  output logic [OW-1:0] ext_out
);
  assign ext_out = {{(OW-IW){ext_op & imm[IW-1]}}, imm};
endmodule

// File: rtl/npc_branch_ext_unit.sv
// npc_branch_ext_unit: branch decision, offset extension and word-addressed branch target with registered copies.
module npc_branch_ext_unit
  import npc_branch_ext_unit_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Branch,
  input  logic          Zero,
  input  logic          Sign,
  input  logic          OverFlow,
  input  logic [5:0]    OP,
  input  logic [4:0]    BranchFlag,
  input  logic          ExtOp,
  input  logic [IW-1:0] Imm16,
  input  logic [AW-1:0] PC_Addr,
  output logic          BranchCtr,
  output logic          Link,
  output logic [AW-1:0] Ext_Out,
  output logic [AW-1:0] B_Addr,
  output logic          BranchCtr_q,
  output logic [AW-1:0] B_Addr_q
);
  logic lt, eq, taken, link_dec;
  assign lt = Sign ^ OverFlow;
  assign eq = Zero;
  always_comb begin
    taken    = 1'b0;
    link_dec = 1'b0;
    case (OP)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLEZ: taken = eq | lt;
      OP_BGTZ: taken = !eq & !lt;
      OP_REGIMM:
        case (BranchFlag)
          RT_BLTZ:   taken = lt;
          RT_BGEZ:   taken = !lt;
          RT_BLTZAL: begin taken = lt;  link_dec = 1'b1; end
          RT_BGEZAL: begin taken = !lt; link_dec = 1'b1; end
          default:   taken = 1'b0;
        endcase
      default: taken = 1'b0;
    endcase
  end
  assign BranchCtr = Branch & taken;
  assign Link      = Branch & link_dec;
  npc_offset_ext #(.IW(IW), .OW(AW)) u_ext (
    .ext_op (ExtOp),
    .imm    (Imm16),
    .ext_out(Ext_Out)
  );
  assign B_Addr = PC_Addr + Ext_Out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCtr_q <= 1'b0;
      B_Addr_q    <= '0;
    end else begin
      BranchCtr_q <= BranchCtr;
      B_Addr_q    <= B_Addr;
    end
  end
endmodule

// File: tb/tb_npc_branch_ext_unit.sv
// tb_npc_branch_ext_unit: directed checks of branch decode, extension, target math and output registers.
module tb_npc_branch_ext_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        Branch = 0, Zero = 0, Sign = 0, OverFlow = 0, ExtOp = 0;
  logic [5:0]  OP = 0;
  logic [4:0]  BranchFlag = 0;
  logic [15:0] Imm16 = 0;
  logic [29:0] PC_Addr = 0;
  logic        BranchCtr, Link, BranchCtr_q;
  logic [29:0] Ext_Out, B_Addr, B_Addr_q;
  int n_cmp = 0, n_bad = 0;

  npc_branch_ext_unit dut (
    .clk(clk), .rst(rst), .Branch(Branch), .Zero(Zero), .Sign(Sign), .OverFlow(OverFlow),
    .OP(OP), .BranchFlag(BranchFlag), .ExtOp(ExtOp), .Imm16(Imm16), .PC_Addr(PC_Addr),
    .BranchCtr(BranchCtr), .Link(Link), .Ext_Out(Ext_Out), .B_Addr(B_Addr),
    .BranchCtr_q(BranchCtr_q), .B_Addr_q(B_Addr_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic br(input logic b, input logic [5:0] op, input logic [4:0] bf,
                    input logic z, input logic s, input logic o);
    Branch = b; OP = op; BranchFlag = bf; Zero = z; Sign = s; OverFlow = o;
    #1;
  endtask

  initial begin
    #2;
    chk("rst_ctr_q", {31'd0, BranchCtr_q}, 0);
    chk("rst_addr_q", {2'd0, B_Addr_q}, 0);
    @(negedge clk); rst = 1'b0;
    br(1, 6'b000100, 0, 1, 0, 0); chk("beq_t", {31'd0, BranchCtr}, 1);
    br(1, 6'b000100, 0, 0, 0, 0); chk("beq_nt", {31'd0, BranchCtr}, 0);
    br(1, 6'b000101, 0, 1, 0, 0); chk("bne_nt", {31'd0, BranchCtr}, 0);
    br(1, 6'b000101, 0, 0, 0, 0); chk("bne_t", {31'd0, BranchCtr}, 1);
    br(0, 6'b000100, 0, 1, 0, 0); chk("nobr", {31'd0, BranchCtr}, 0);
    br(1, 6'b000001, 5'b00000, 0, 1, 0); chk("bltz_t", {31'd0, BranchCtr}, 1);
    chk("bltz_link", {31'd0, Link}, 0);
    br(1, 6'b000001, 5'b00000, 0, 1, 1); chk("bltz_ovf", {31'd0, BranchCtr}, 0);
    br(1, 6'b000001, 5'b00001, 0, 1, 1); chk("bgez_ovf", {31'd0, BranchCtr}, 1);
    br(1, 6'b000111, 0, 0, 0, 0); chk("bgtz_t", {31'd0, BranchCtr}, 1);
    br(1, 6'b000111, 0, 1, 0, 0); chk("bgtz_eq", {31'd0, BranchCtr}, 0);
    br(1, 6'b000110, 0, 1, 0, 0); chk("blez_eq", {31'd0, BranchCtr}, 1);
    br(1, 6'b000110, 0, 0, 0, 0); chk("blez_pos", {31'd0, BranchCtr}, 0);
    br(1, 6'b000001, 5'b10001, 0, 0, 0); chk("bgezal_t", {31'd0, BranchCtr}, 1);
    chk("bgezal_link", {31'd0, Link}, 1);
    br(1, 6'b000001, 5'b10000, 0, 0, 0); chk("bltzal_nt", {31'd0, BranchCtr}, 0);
    chk("bltzal_link", {31'd0, Link}, 1);
    br(0, 6'b000001, 5'b10000, 0, 1, 0); chk("al_nobr_link", {31'd0, Link}, 0);
    br(1, 6'b000001, 5'b00010, 0, 1, 0); chk("regimm_bad", {31'd0, BranchCtr}, 0);
    chk("regimm_bad_link", {31'd0, Link}, 0);
    br(1, 6'b100011, 0, 1, 1, 0); chk("op_other", {31'd0, BranchCtr}, 0);

    Imm16 = 16'h8000; ExtOp = 1; #1; chk("sext_neg", {2'd0, Ext_Out}, 32'h3FFF8000);
    ExtOp = 0; #1; chk("zext", {2'd0, Ext_Out}, 32'h00008000);
    Imm16 = 16'h7FFF; ExtOp = 1; #1; chk("sext_pos", {2'd0, Ext_Out}, 32'h00007FFF);
    PC_Addr = 30'h10; Imm16 = 16'hFFFF; ExtOp = 1; #1; chk("tgt_back", {2'd0, B_Addr}, 32'h0000000F);
    PC_Addr = 30'h3FFFFFFF; Imm16 = 16'h0001; #1; chk("tgt_wrap_hi", {2'd0, B_Addr}, 0);
    PC_Addr = 30'h0; Imm16 = 16'hFFFF; #1; chk("tgt_wrap_lo", {2'd0, B_Addr}, 32'h3FFFFFFF);
    PC_Addr = 30'h3FFFFFFF; Imm16 = 16'hFFFF; ExtOp = 0; #1; chk("tgt_zext_wrap", {2'd0, B_Addr}, 32'h0000FFFE);

    // registered path
    @(negedge clk);
    br(1, 6'b000100, 0, 1, 0, 0); PC_Addr = 30'h10; Imm16 = 16'h0010; ExtOp = 1;
    @(posedge clk); #1;
    chk("q_ctr", {31'd0, BranchCtr_q}, 1);
    chk("q_addr", {2'd0, B_Addr_q}, 32'h20);
    Zero = 0; PC_Addr = 30'h100; #1;
    chk("q_hold_ctr", {31'd0, BranchCtr_q}, 1);
    chk("q_hold_addr", {2'd0, B_Addr_q}, 32'h20);
    chk("comb_mid", {2'd0, B_Addr}, 32'h110);
    @(posedge clk); #1;
    chk("q2_ctr", {31'd0, BranchCtr_q}, 0);
    chk("q2_addr", {2'd0, B_Addr_q}, 32'h110);
    Zero = 1; PC_Addr = 30'h200;
    @(posedge clk); #1;
    chk("q3_ctr", {31'd0, BranchCtr_q}, 1);
    chk("q3_addr", {2'd0, B_Addr_q}, 32'h210);

    // async reset mid-cycle
    #2 rst = 1'b1; #1;
    chk("arst_ctr", {31'd0, BranchCtr_q}, 0);
    chk("arst_addr", {2'd0, B_Addr_q}, 0);
    PC_Addr = 30'h300; #1;
    chk("arst_comb_ctr", {31'd0, BranchCtr}, 1);
    chk("arst_comb_addr", {2'd0, B_Addr}, 32'h310);
    @(posedge clk); #1;
    chk("arst_hold_addr", {2'd0, B_Addr_q}, 0);
    @(negedge clk); rst = 1'b0; PC_Addr = 30'h400; #1;
    chk("rel_pre_addr", {2'd0, B_Addr_q}, 0);
    @(posedge clk); #1;
    chk("rel_ctr", {31'd0, BranchCtr_q}, 1);
    chk("rel_addr", {2'd0, B_Addr_q}, 32'h410);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
